// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the memory/decode/writeback stages: write-back source select,
// load funct3 codes and the register-file write bundle.
package writeback_stage_pkg;

   localparam logic [1:0] WB_NONE = 2'd0;
   localparam logic [1:0] WB_ALU  = 2'd1;
   localparam logic [1:0] WB_LOAD = 2'd2;
   localparam logic [1:0] WB_RSVD = 2'd3;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        we;
   } wb_write_t;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Combinational load alignment: picks the byte/half/word out of the dmem word
// and sign- or zero-extends it; flags funct3 codes that are not loads.
module writeback_stage_load_align
   import writeback_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] data,
   output logic        bad_f3
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      // Halfword select uses addr[1] only; addr[0] is ignored.
      half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      data   = 32'd0;
      bad_f3 = 1'b0;
      case (funct3)
         F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   data = {{16{half_sel[15]}}, half_sel};
         F3_LW:   data = rdata;
         F3_LBU:  data = {24'd0, byte_sel};
         F3_LHU:  data = {16'd0, half_sel};
         default: bad_f3 = 1'b1;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires ALU results directly, waits for dmem data on loads,
// and drives the register-file write port plus forwarding/stall/error signals.
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [4:0]  mem_rd,
   input  logic [1:0]  mem_wb_sel,
   input  logic [31:0] mem_alu_result,
   input  logic [2:0]  mem_funct3,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic [4:0]  wd,
   output logic [31:0] w_data,
   output logic        w_enable,
   output logic        stall_req,
   output logic        fwd_valid,
   output logic        wb_err
);

   localparam logic [0:0] ST_IDLE      = 1'b0;
   localparam logic [0:0] ST_WAIT_LOAD = 1'b1;

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

   logic [0:0]       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
   logic [4:0]       ld_rd_reg, ld_rd_next;
   logic [1:0]       ld_addr_reg, ld_addr_next;
   logic [2:0]       ld_f3_reg, ld_f3_next;
   logic             park_valid_reg, park_valid_next;
   wb_write_t        park_reg, park_next;
   logic [4:0]       wd_reg, wd_next;
   logic [31:0]      w_data_reg, w_data_next;
   logic             w_enable_reg, w_enable_next;
   logic             wb_err_reg, wb_err_next;

   logic [31:0]      align_data;
   logic             align_bad;
   logic             handshake;
   wb_write_t        load_wr;

   writeback_stage_load_align u_load_align (
      .rdata  (dmem_rdata),
      .addr   (ld_addr_reg),
      .funct3 (ld_f3_reg),
      .data   (align_data),
      .bad_f3 (align_bad)
   );

   // A parked load result blocks new ops until it has been written.
   assign mem_ready = (state_reg == ST_IDLE) && !stall && !park_valid_reg;
   assign handshake = mem_valid && mem_ready;
   assign stall_req = (state_reg == ST_WAIT_LOAD);
   assign wd        = wd_reg;
   assign w_data    = w_data_reg;
   assign w_enable  = w_enable_reg;
   assign fwd_valid = w_enable_reg;
   assign wb_err    = wb_err_reg;

   always_comb begin
      load_wr.rd   = ld_rd_reg;
      load_wr.data = align_bad ? 32'd0 : align_data;
      load_wr.we   = !align_bad && (ld_rd_reg != 5'd0);
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      cnt_inc         = cnt_reg + 1'b1;
      ld_rd_next      = ld_rd_reg;
      ld_addr_next    = ld_addr_reg;
      ld_f3_next      = ld_f3_reg;
      park_valid_next = park_valid_reg;
      park_next       = park_reg;
      wd_next         = wd_reg;
      w_data_next     = w_data_reg;
      w_enable_next   = w_enable_reg;
      wb_err_next     = 1'b0;

      if (state_reg == ST_IDLE) begin
         // Any rvalid here belongs to no outstanding load.
         if (dmem_rvalid) begin
            wb_err_next = 1'b1;
         end
         if (!stall) begin
            if (park_valid_reg) begin
               wd_next         = park_reg.rd;
               w_data_next     = park_reg.data;
               w_enable_next   = park_reg.we;
               park_valid_next = 1'b0;
            end else begin
               w_enable_next = 1'b0;
               if (handshake) begin
                  if (mem_wb_sel == WB_ALU) begin
                     wd_next       = mem_rd;
                     w_data_next   = mem_alu_result;
                     w_enable_next = (mem_rd != 5'd0);
                  end else if (mem_wb_sel == WB_LOAD) begin
                     ld_rd_next   = mem_rd;
                     ld_addr_next = mem_alu_result[1:0];
                     ld_f3_next   = mem_funct3;
                     cnt_next     = '0;
                     state_next   = ST_WAIT_LOAD;
                  end
               end
            end
         end
      end else begin
         cnt_next = cnt_inc;
         if (dmem_rvalid) begin
            state_next  = ST_IDLE;
            wb_err_next = align_bad;
            if (stall) begin
               park_valid_next = 1'b1;
               park_next       = load_wr;
            end else begin
               wd_next       = load_wr.rd;
               w_data_next   = load_wr.data;
               w_enable_next = load_wr.we;
            end
         end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_VAL)) begin
            state_next  = ST_IDLE;
            wb_err_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= '0;
         ld_rd_reg      <= 5'd0;
         ld_addr_reg    <= 2'd0;
         ld_f3_reg      <= 3'd0;
         park_valid_reg <= 1'b0;
         park_reg       <= '0;
         wd_reg         <= 5'd0;
         w_data_reg     <= 32'd0;
         w_enable_reg   <= 1'b0;
         wb_err_reg     <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         ld_rd_reg      <= ld_rd_next;
         ld_addr_reg    <= ld_addr_next;
         ld_f3_reg      <= ld_f3_next;
         park_valid_reg <= park_valid_next;
         park_reg       <= park_next;
         wd_reg         <= wd_next;
         w_data_reg     <= w_data_next;
         w_enable_reg   <= w_enable_next;
         wb_err_reg     <= wb_err_next;
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: ALU pass-through, aligned loads, timeout,
// stray rvalid, stall parking and reset during an outstanding load.
module tb_writeback_stage;
   import writeback_stage_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_rd;
   logic [1:0]  mem_wb_sel;
   logic [31:0] mem_alu_result;
   logic [2:0]  mem_funct3;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic [4:0]  wd;
   logic [31:0] w_data;
   logic        w_enable;
   logic        stall_req;
   logic        fwd_valid;
   logic        wb_err;

   int total = 0;
   int bad   = 0;

   writeback_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .mem_rd         (mem_rd),
      .mem_wb_sel     (mem_wb_sel),
      .mem_alu_result (mem_alu_result),
      .mem_funct3     (mem_funct3),
      .dmem_rvalid    (dmem_rvalid),
      .dmem_rdata     (dmem_rdata),
      .wd             (wd),
      .w_data         (w_data),
      .w_enable       (w_enable),
      .stall_req      (stall_req),
      .fwd_valid      (fwd_valid),
      .wb_err         (wb_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] addr;
      logic [2:0]  f3;
      int          dly;
      logic [31:0] rdata;
      logic [31:0] exp_data;
      logic        chk_data;
      logic        exp_we;
      logic        exp_err;
   } ld_vec_t;

   ld_vec_t vecs [7];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      mem_valid      = 1'b0;
      mem_rd         = 5'd0;
      mem_wb_sel     = WB_NONE;
      mem_alu_result = 32'd0;
      mem_funct3     = 3'd0;
      dmem_rvalid    = 1'b0;
      dmem_rdata     = 32'd0;
   endtask

   task automatic issue(input logic [1:0] sel, input logic [4:0] rd,
                        input logic [31:0] val, input logic [2:0] f3);
      mem_valid      = 1'b1;
      mem_wb_sel     = sel;
      mem_rd         = rd;
      mem_alu_result = val;
      mem_funct3     = f3;
   endtask

   initial begin
      vecs[0] = '{5'd7,  32'h0000_1003, F3_LB,  3, 32'h8011_2233, 32'hFFFF_FF80, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{5'd9,  32'h0000_2002, F3_LHU, 1, 32'hBEEF_1234, 32'h0000_BEEF, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{5'd0,  32'h0000_0010, F3_LW,  2, 32'h1234_5678, 32'h0,         1'b0, 1'b0, 1'b0};
      vecs[3] = '{5'd3,  32'h0000_0003, F3_LH,  1, 32'h8001_5555, 32'hFFFF_8001, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{5'd4,  32'h0000_0000, F3_LB,  1, 32'h0000_007F, 32'h0000_007F, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{5'd6,  32'h0000_0006, F3_LBU, 2, 32'h00AB_0000, 32'h0000_00AB, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{5'd8,  32'h0000_0000, 3'b011, 1, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 1'b1};

      reset = 1'b1;
      stall = 1'b0;
      clear_inputs();
      tick();
      tick();
      chk("rst_we",    {31'd0, w_enable},  32'd0);
      chk("rst_wd",    {27'd0, wd},        32'd0);
      chk("rst_wdata", w_data,             32'd0);
      chk("rst_err",   {31'd0, wb_err},    32'd0);
      chk("rst_sreq",  {31'd0, stall_req}, 32'd0);
      chk("rst_fwd",   {31'd0, fwd_valid}, 32'd0);
      chk("rst_ready", {31'd0, mem_ready}, 32'd1);
      $display("reset: we=%0d wd=%0d ready=%0d", w_enable, wd, mem_ready);
      reset = 1'b0;
      tick();

      // ALU pass-through
      issue(WB_ALU, 5'd5, 32'hDEAD_BEEF, 3'd0);
      chk("alu_ready_pre", {31'd0, mem_ready}, 32'd1);
      tick();
      clear_inputs();
      chk("alu_we",    {31'd0, w_enable},  32'd1);
      chk("alu_wd",    {27'd0, wd},        32'd5);
      chk("alu_wdata", w_data,             32'hDEAD_BEEF);
      chk("alu_fwd",   {31'd0, fwd_valid}, 32'd1);
      chk("alu_ready", {31'd0, mem_ready}, 32'd1);
      $display("alu rd=5: we=%0d wd=%0d data=%h", w_enable, wd, w_data);
      tick();
      chk("alu_we_drop", {31'd0, w_enable}, 32'd0);

      // ALU with rd=0 and a NONE op never write
      issue(WB_ALU, 5'd0, 32'h1111_1111, 3'd0);
      tick();
      clear_inputs();
      chk("alu_rd0_we", {31'd0, w_enable}, 32'd0);
      $display("alu rd=0: we=%0d", w_enable);
      issue(WB_NONE, 5'd2, 32'h2222_2222, 3'd0);
      tick();
      clear_inputs();
      chk("none_we", {31'd0, w_enable}, 32'd0);
      $display("none rd=2: we=%0d", w_enable);

      // Load vectors
      for (int i = 0; i < 7; i++) begin
         issue(WB_LOAD, vecs[i].rd, vecs[i].addr, vecs[i].f3);
         tick();
         clear_inputs();
         for (int c = 1; c <= vecs[i].dly; c++) begin
            chk($sformatf("ld%0d_sreq_c%0d", i, c), {31'd0, stall_req}, 32'd1);
            chk($sformatf("ld%0d_ready_c%0d", i, c), {31'd0, mem_ready}, 32'd0);
            if (c == vecs[i].dly) begin
               dmem_rvalid = 1'b1;
               dmem_rdata  = vecs[i].rdata;
            end
            tick();
         end
         clear_inputs();
         chk($sformatf("ld%0d_sreq_end", i), {31'd0, stall_req}, 32'd0);
         chk($sformatf("ld%0d_we", i), {31'd0, w_enable}, {31'd0, vecs[i].exp_we});
         chk($sformatf("ld%0d_err", i), {31'd0, wb_err}, {31'd0, vecs[i].exp_err});
         if (vecs[i].chk_data) begin
            chk($sformatf("ld%0d_wdata", i), w_data, vecs[i].exp_data);
         end
         if (vecs[i].exp_we) begin
            chk($sformatf("ld%0d_wd", i), {27'd0, wd}, {27'd0, vecs[i].rd});
         end
         $display("load %0d rd=%0d f3=%b addr=%h: we=%0d data=%h err=%0d",
                  i, vecs[i].rd, vecs[i].f3, vecs[i].addr, w_enable, w_data, wb_err);
         tick();
         chk($sformatf("ld%0d_err_drop", i), {31'd0, wb_err}, 32'd0);
      end

      // Timeout after 4 waiting cycles, then a stray rvalid
      issue(WB_LOAD, 5'd10, 32'h0000_0000, F3_LW);
      tick();
      clear_inputs();
      for (int c = 1; c <= 4; c++) begin
         chk($sformatf("to_sreq_c%0d", c), {31'd0, stall_req}, 32'd1);
         chk($sformatf("to_err_c%0d", c), {31'd0, wb_err}, 32'd0);
         tick();
      end
      chk("to_err",  {31'd0, wb_err},    32'd1);
      chk("to_we",   {31'd0, w_enable},  32'd0);
      chk("to_sreq", {31'd0, stall_req}, 32'd0);
      $display("timeout: err=%0d we=%0d sreq=%0d", wb_err, w_enable, stall_req);
      tick();
      chk("to_err_drop", {31'd0, wb_err}, 32'd0);
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h5A5A_5A5A;
      tick();
      clear_inputs();
      chk("stray_err", {31'd0, wb_err},   32'd1);
      chk("stray_we",  {31'd0, w_enable}, 32'd0);
      $display("stray rvalid after timeout: err=%0d we=%0d", wb_err, w_enable);
      tick();
      chk("stray_err_drop", {31'd0, wb_err}, 32'd0);

      // rvalid during stall: result parked, queued ALU op not lost
      issue(WB_LOAD, 5'd11, 32'h0000_0000, F3_LW);
      tick();
      clear_inputs();
      stall       = 1'b1;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hCAFE_F00D;
      chk("park_ready_c1", {31'd0, mem_ready}, 32'd0);
      tick();
      clear_inputs();
      issue(WB_ALU, 5'd12, 32'h0000_1234, 3'd0);
      chk("park_we_c2",    {31'd0, w_enable},  32'd0);
      chk("park_sreq_c2",  {31'd0, stall_req}, 32'd0);
      chk("park_ready_c2", {31'd0, mem_ready}, 32'd0);
      tick();
      stall = 1'b0;
      chk("park_we_c3",    {31'd0, w_enable},  32'd0);
      chk("park_ready_c3", {31'd0, mem_ready}, 32'd0);
      tick();
      chk("park_we",    {31'd0, w_enable}, 32'd1);
      chk("park_wd",    {27'd0, wd},       32'd11);
      chk("park_wdata", w_data,            32'hCAFE_F00D);
      chk("park_ready", {31'd0, mem_ready}, 32'd1);
      $display("parked load rd=11: we=%0d wd=%0d data=%h", w_enable, wd, w_data);
      tick();
      clear_inputs();
      chk("after_park_we",    {31'd0, w_enable}, 32'd1);
      chk("after_park_wd",    {27'd0, wd},       32'd12);
      chk("after_park_wdata", w_data,            32'h0000_1234);
      $display("alu after park rd=12: we=%0d wd=%0d data=%h", w_enable, wd, w_data);

      // Reset while a load is outstanding
      issue(WB_LOAD, 5'd13, 32'h0000_0000, F3_LW);
      tick();
      clear_inputs();
      chk("mid_sreq_pre", {31'd0, stall_req}, 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_sreq",  {31'd0, stall_req}, 32'd0);
      chk("mid_rst_we",    {31'd0, w_enable},  32'd0);
      chk("mid_rst_wd",    {27'd0, wd},        32'd0);
      chk("mid_rst_wdata", w_data,             32'd0);
      $display("reset mid-load: sreq=%0d we=%0d wd=%0d", stall_req, w_enable, wd);
      tick();
      reset = 1'b0;
      tick();
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h7777_7777;
      tick();
      clear_inputs();
      chk("post_rst_err", {31'd0, wb_err},   32'd1);
      chk("post_rst_we",  {31'd0, w_enable}, 32'd0);
      tick();
      chk("post_rst_we2", {31'd0, w_enable}, 32'd0);
      $display("late rvalid after reset: we=%0d", w_enable);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
